// File: rtl/pipeline_step_ctrl.sv
// Run/step/pause controller that gates a pipeline clock enable and drains it after a HALT fetch.
// Optional breakpoint on the IF/ID PC is compiled in with `define STEP_CTRL_BKPT_EN.
module pipeline_step_ctrl #(
    parameter logic [5:0] HALT_OPCODE  = 6'b111111,
    parameter int         DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_code,
    output logic        cmd_ready,
    input  logic [31:0] instruction,
    input  logic [9:0]  PC_IFID,
`ifdef STEP_CTRL_BKPT_EN
    input  logic        bkpt_en,
    input  logic [9:0]  bkpt_pc,
    output logic        bkpt_hit,
`endif
    output logic        pipe_en,
    output logic [2:0]  state,
    output logic        done,
    output logic [31:0] cycle_count
);
    localparam int CW = $clog2(DRAIN_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_PAUSE = 2'b11;

    state_t        state_q, state_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d;
    logic [31:0]   cycle_count_q, cycle_count_d;
    logic          accept, halt_seen, go_cmd;
    logic          bkpt_match;
`ifdef STEP_CTRL_BKPT_EN
    logic          bkpt_hit_q, bkpt_hit_d;
`endif

    assign pipe_en     = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
    assign cmd_ready   = (state_q == S_IDLE) || (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign state       = state_q;
    assign cycle_count = cycle_count_q;

    assign accept    = cmd_valid && cmd_ready;
    assign halt_seen = pipe_en && (instruction[31:26] == HALT_OPCODE);
    assign go_cmd    = accept && ((cmd_code == CMD_RUN) || (cmd_code == CMD_STEP));

`ifdef STEP_CTRL_BKPT_EN
    assign bkpt_match = (state_q == S_RUN) && bkpt_en && (PC_IFID == bkpt_pc);
    assign bkpt_hit   = bkpt_hit_q;
`else
    assign bkpt_match = 1'b0;
    logic unused_pc;
    assign unused_pc = ^PC_IFID;
`endif
    logic unused_instr;
    assign unused_instr = ^instruction[25:0];

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        cycle_count_d = cycle_count_q;
`ifdef STEP_CTRL_BKPT_EN
        bkpt_hit_d    = bkpt_hit_q;
        if (go_cmd) bkpt_hit_d = 1'b0;
`endif
        if (pipe_en && (cycle_count_q != 32'hFFFF_FFFF))
            cycle_count_d = cycle_count_q + 32'd1;

        case (state_q)
            S_IDLE: begin
                if (accept && cmd_code == CMD_RUN)  state_d = S_RUN;
                if (accept && cmd_code == CMD_STEP) state_d = S_STEP;
            end
            S_RUN: begin
                // HALT outranks both a breakpoint and a coincident PAUSE
                if (halt_seen) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = CW'(DRAIN_CYCLES - 1);
                end else if (bkpt_match) begin
                    state_d = S_IDLE;
`ifdef STEP_CTRL_BKPT_EN
                    bkpt_hit_d = 1'b1;
`endif
                end else if (accept && cmd_code == CMD_PAUSE) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                if (halt_seen) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = CW'(DRAIN_CYCLES - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == '0) state_d = S_DONE;
                else                   drain_cnt_d = drain_cnt_q - CW'(1);
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            drain_cnt_q   <= '0;
            cycle_count_q <= '0;
`ifdef STEP_CTRL_BKPT_EN
            bkpt_hit_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            cycle_count_q <= cycle_count_d;
`ifdef STEP_CTRL_BKPT_EN
            bkpt_hit_q    <= bkpt_hit_d;
`endif
        end
    end
endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Directed bench for pipeline_step_ctrl: run/halt/drain, stepping, pause+halt, reset mid-drain, saturation.
module tb_pipeline_step_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_code;
    logic        cmd_ready;
    logic [31:0] instruction;
    logic [9:0]  PC_IFID;
    logic        pipe_en;
    logic [2:0]  state;
    logic        done;
    logic [31:0] cycle_count;
`ifdef STEP_CTRL_BKPT_EN
    logic        bkpt_en;
    logic [9:0]  bkpt_pc;
    logic        bkpt_hit;
`endif

    int checks = 0;
    int errors = 0;
    int pe_cnt = 0;

    localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

    pipeline_step_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ready(cmd_ready), .instruction(instruction), .PC_IFID(PC_IFID),
`ifdef STEP_CTRL_BKPT_EN
        .bkpt_en(bkpt_en), .bkpt_pc(bkpt_pc), .bkpt_hit(bkpt_hit),
`endif
        .pipe_en(pipe_en), .state(state), .done(done), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // counts enabled cycles independently of the DUT counter
    always @(negedge clk) if (pipe_en === 1'b1) pe_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        pe_cnt = 0;
    endtask

    task automatic send(input logic [1:0] code);
        cmd_valid = 1'b1;
        cmd_code  = code;
        tick();
        cmd_valid = 1'b0;
        cmd_code  = 2'b00;
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_code = 2'b00;
        instruction = 32'h0; PC_IFID = 10'd0;
`ifdef STEP_CTRL_BKPT_EN
        bkpt_en = 1'b0; bkpt_pc = 10'd0;
`endif
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pipe_en", 32'(pipe_en), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("idle_hold", 32'(state), 32'd0);

        // RUN, HALT during 10th enabled cycle, then 4 drain cycles
        send(2'b01);
        chk("run_state", 32'(state), 32'd1);
        chk("run_pipe_en", 32'(pipe_en), 32'd1);
        repeat (9) tick();
        instruction = HALT_INSTR;
        tick();
        instruction = 32'h0;
        chk("halt_drain", 32'(state), 32'd3);
        chk("halt_cc10", cycle_count, 32'd10);
        chk("drain_ready", 32'(cmd_ready), 32'd0);
        repeat (3) tick();
        chk("drain_still", 32'(state), 32'd3);
        tick();
        chk("done_state", 32'(state), 32'd4);
        chk("done_flag", 32'(done), 32'd1);
        chk("done_cc14", cycle_count, 32'd14);
        chk("done_ready", 32'(cmd_ready), 32'd0);
        chk("done_pe_cnt", 32'(pe_cnt), 32'd14);
        send(2'b01);
        tick();
        chk("done_sticky", 32'(state), 32'd4);
        chk("done_pipe_en", 32'(pipe_en), 32'd0);

        // three STEPs separated by two idle cycles
        do_reset();
        tick();
        repeat (3) begin
            send(2'b10);
            chk("step_pulse", 32'(pipe_en), 32'd1);
            tick();
            chk("step_end", 32'(pipe_en), 32'd0);
            tick();
        end
        chk("step_state", 32'(state), 32'd0);
        chk("step_cc3", cycle_count, 32'd3);
        chk("step_pe_cnt", 32'(pe_cnt), 32'd3);

        // PAUSE coinciding with HALT still drains
        do_reset();
        tick();
        send(2'b01);
        tick();
        cmd_valid = 1'b1; cmd_code = 2'b11; instruction = HALT_INSTR;
        tick();
        cmd_valid = 1'b0; cmd_code = 2'b00; instruction = 32'h0;
        chk("pause_halt_drain", 32'(state), 32'd3);
        repeat (3) tick();
        chk("pause_halt_wait", 32'(done), 32'd0);
        tick();
        chk("pause_halt_done", 32'(done), 32'd1);
        chk("pause_halt_cc", cycle_count, 32'd6);

        // reset during the second DRAIN cycle
        do_reset();
        tick();
        send(2'b01);
        instruction = HALT_INSTR;
        tick();
        instruction = 32'h0;
        tick();
        chk("mid_drain", 32'(state), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_pipe_en", 32'(pipe_en), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_cc", cycle_count, 32'd0);
        pe_cnt = 0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_cc", cycle_count, 32'd0);
        chk("post_rst_no_pe", 32'(pe_cnt), 32'd0);

        // saturation, RUN/STEP ignored in RUN, PAUSE back to IDLE
        do_reset();
        force dut.cycle_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_count_q;
        tick();
        send(2'b01);
        chk("sat_start", cycle_count, 32'hFFFF_FFFE);
        repeat (5) tick();
        chk("sat_hold", cycle_count, 32'hFFFF_FFFF);
        send(2'b10);
        chk("run_ignores_step", 32'(state), 32'd1);
        send(2'b11);
        chk("pause_idle", 32'(state), 32'd0);
        chk("pause_pipe_en", 32'(pipe_en), 32'd0);
        chk("sat_final", cycle_count, 32'hFFFF_FFFF);

`ifdef STEP_CTRL_BKPT_EN
        do_reset();
        bkpt_en = 1'b1; bkpt_pc = 10'd12; PC_IFID = 10'd10;
        tick();
        send(2'b01);
        tick();
        PC_IFID = 10'd11;
        tick();
        chk("bkpt_before", 32'(state), 32'd1);
        PC_IFID = 10'd12;
        tick();
        PC_IFID = 10'd13;
        chk("bkpt_idle", 32'(state), 32'd0);
        chk("bkpt_hit_set", 32'(bkpt_hit), 32'd1);
        send(2'b10);
        chk("bkpt_hit_clr", 32'(bkpt_hit), 32'd0);
        bkpt_en = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_step_ctrl.md
PIPELINE_STEP_CTRL -- requirements
Module: pipeline_step_ctrl

Interface
REQ-001 SHALL have parameter HALT_OPCODE, default 6'b111111, the opcode that ends a program.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4, the number of enabled cycles after the HALT fetch needed to retire the HALT through WB.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port cmd_valid, input, 1, host command present.
REQ-006 SHALL have port cmd_code, input, 2, with encodings 00 NOP, 01 RUN, 10 STEP, 11 PAUSE.
REQ-007 SHALL have port cmd_ready, output, 1, command accepted this edge if cmd_valid=1.
REQ-008 SHALL have port instruction, input, 32, the IF/ID instruction; bits [31:26] are watched.
REQ-009 SHALL have port PC_IFID, input, 10, the IF/ID PC, used only by the breakpoint feature.
REQ-010 SHALL have port pipe_en, output, 1, pipeline clock enable.
REQ-011 SHALL have port state, output, 3, encoded as IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4.
REQ-012 SHALL have port done, output, 1, high in DONE.
REQ-013 SHALL have port cycle_count, output, 32, the number of cycles with pipe_en=1.

Function
REQ-014 SHALL drive pipe_en combinationally from the registered state: 1 in RUN, STEP and DRAIN; 0 in IDLE and DONE.
REQ-015 SHALL drive cmd_ready=1 in IDLE and RUN, and 0 in STEP, DRAIN and DONE.
REQ-016 SHALL accept a command only on an edge where cmd_valid=1 and cmd_ready=1; NOP is accepted with no effect.
REQ-017 SHALL, in IDLE: go to RUN on RUN, go to STEP on STEP, and stay in IDLE on PAUSE.
REQ-018 SHALL hold STEP for exactly one cycle, then go to IDLE, giving exactly one pipe_en pulse per accepted STEP.
REQ-019 SHALL, in RUN, go to IDLE on an accepted PAUSE; an accepted RUN or STEP in RUN is consumed with no effect.
REQ-020 SHALL, in RUN or STEP, on an edge where pipe_en=1 and instruction[31:26]=HALT_OPCODE, go to DRAIN with the drain counter loaded to DRAIN_CYCLES-1.
REQ-021 SHALL, in DRAIN, decrement the drain counter every cycle and go to DONE on the edge where it equals 0 (exactly DRAIN_CYCLES enabled cycles).
REQ-022 SHALL keep DONE sticky until reset; all commands are refused (cmd_ready=0).
REQ-023 SHALL, when a HALT opcode and an accepted PAUSE coincide in RUN, go to DRAIN; the PAUSE is consumed and ignored.
REQ-024 SHALL increment cycle_count on each edge with pipe_en=1, saturating at 32'hFFFFFFFF without wrap.
REQ-025 SHALL have the drain counter at least clog2(DRAIN_CYCLES)+1 bits wide; DRAIN_CYCLES=1 goes to DONE after one DRAIN cycle.

Reset
REQ-026 SHALL, while reset=0, immediately force: state=IDLE, pipe_en=0, cmd_ready=1, done=0, cycle_count=0, drain counter=0, bkpt_hit=0.
REQ-027 SHALL abandon a run, step or drain on mid-operation reset, with no pipe_en pulse after reset asserts.
REQ-028 SHALL release from reset synchronously to the next rising clk edge while in IDLE.

Configuration
REQ-029 SHALL, with STEP_CTRL_BKPT_EN defined, add inputs bkpt_en (1) and bkpt_pc (10) and output bkpt_hit (1).
REQ-030 SHALL, with STEP_CTRL_BKPT_EN defined, in RUN with bkpt_en=1 and PC_IFID==bkpt_pc, go to IDLE on the next edge and set bkpt_hit.
REQ-031 SHALL clear bkpt_hit on the next accepted RUN or STEP.
REQ-032 SHALL give a HALT opcode priority over a breakpoint match in the same cycle, going to DRAIN with bkpt_hit unchanged.
REQ-033 SHALL, without STEP_CTRL_BKPT_EN, omit bkpt_en, bkpt_pc and bkpt_hit, and have no breakpoint logic.

Verification
REQ-034 SHALL cover: reset low then high; RUN accepted; HALT opcode fetched at cycle 10 -> pipe_en high for 10+4 cycles, done=1, cycle_count=14, cmd_ready=0.
REQ-035 SHALL cover: three STEP commands spaced by two idle cycles -> exactly three single-cycle pipe_en pulses, state back to IDLE, cycle_count=3.
REQ-036 SHALL cover: PAUSE asserted in the same cycle the HALT opcode is on instruction -> DRAIN entered, done after 4 further cycles.
REQ-037 SHALL cover: reset asserted during the second DRAIN cycle -> pipe_en=0 immediately; after release, state=IDLE and cycle_count=0.
REQ-038 SHALL cover: cycle_count forced near 32'hFFFFFFFE and RUN for 5 cycles -> holds 32'hFFFFFFFF.
REQ-039 SHALL cover, with STEP_CTRL_BKPT_EN: bkpt_pc=10'd12, bkpt_en=1, RUN -> IDLE one edge after PC_IFID=12 and bkpt_hit=1; a following STEP clears bkpt_hit.
